// File: rtl/data_swapper_stream_64_if.sv
// Stream bundle around the lane swapper: upstream beat (i_*) and downstream beat (o_*).
// The slave modport is the swapper's view, the master modport is the surrounding environment's view.
interface data_swapper_stream_64_if;
    logic [63:0] i_tdata;
    logic [2:0]  i_tuser;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic [2:0]  o_tuser;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;

    modport slave (
        input  i_tdata, i_tuser, i_tlast, i_tvalid,
        output i_tready,
        output o_tdata, o_tuser, o_tlast, o_tvalid,
        input  o_tready
    );

    modport master (
        output i_tdata, i_tuser, i_tlast, i_tvalid,
        input  i_tready,
        input  o_tdata, o_tuser, o_tlast, o_tvalid,
        output o_tready
    );
endinterface

// File: rtl/data_swapper_stream_64.sv
// 64-bit stream lane swapper: per-packet swap config, one-cycle latency, output register plus
// one skid register so the upstream ready can be a flop while sustaining full throughput.
module data_swapper_stream_64 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [2:0]  swap_lanes,
    output logic [31:0] pkt_count,
    data_swapper_stream_64_if.slave bus
);
    localparam int DATA_W = 64;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cfg_q, cfg_d;
    logic [2:0]          lanes_p0;
    logic                vld_p0;
    logic                out_fire;
    logic [DATA_W-1:0]   data_p0;

    logic [DATA_W-1:0]   data_p1;
    logic [2:0]          user_p1;
    logic                last_p1;
    logic                vld_p1, vld_p1_d;
    logic [DATA_W-1:0]   skid_data_p1;
    logic [2:0]          skid_user_p1;
    logic                skid_last_p1;
    logic                skid_vld_p1, skid_vld_p1_d;
    logic                load_out, out_from_skid, load_skid;
    logic                rdy_q;
    logic [31:0]         pkt_cnt_q;

    // Swaps compose in a fixed order: halves, then 16-bit words, then bytes.
    function automatic logic [DATA_W-1:0] lane_swap(input logic [DATA_W-1:0] d,
                                                    input logic [2:0] sel);
        logic [DATA_W-1:0] x;
        x = d;
        if (sel[2]) x = {x[31:0], x[63:32]};
        if (sel[1]) x = {x[47:32], x[63:48], x[15:0], x[31:16]};
        if (sel[0]) x = {x[55:48], x[63:56], x[39:32], x[47:40],
                         x[23:16], x[31:24], x[7:0],   x[15:8]};
        return x;
    endfunction

    // ---- p0: accept and swap ----
    assign vld_p0   = bus.i_tvalid & rdy_q;
    assign out_fire = vld_p1 & bus.o_tready;
    assign lanes_p0 = (state_q == IDLE) ? swap_lanes : cfg_q;
    assign data_p0  = lane_swap(bus.i_tdata, lanes_p0);

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        case (state_q)
            IDLE: begin
                if (vld_p0) begin
                    cfg_d = swap_lanes;
                    if (!bus.i_tlast) state_d = IN_PKT;
                end
            end
            IN_PKT: begin
                if (vld_p0 && bus.i_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    // Skid is only written while the output holds a stalled beat; it always drains first.
    always_comb begin
        vld_p1_d      = vld_p1;
        skid_vld_p1_d = skid_vld_p1;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        if (!vld_p1 || out_fire) begin
            if (skid_vld_p1) begin
                load_out      = 1'b1;
                out_from_skid = 1'b1;
                vld_p1_d      = 1'b1;
                skid_vld_p1_d = 1'b0;
            end else if (vld_p0) begin
                load_out = 1'b1;
                vld_p1_d = 1'b1;
            end else begin
                vld_p1_d = 1'b0;
            end
        end else if (vld_p0) begin
            load_skid     = 1'b1;
            skid_vld_p1_d = 1'b1;
        end
        if (clear) begin
            vld_p1_d      = 1'b0;
            skid_vld_p1_d = 1'b0;
            load_out      = 1'b0;
            load_skid     = 1'b0;
        end
    end

    // ---- p1: output register and skid register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cfg_q       <= 3'b000;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_q       <= 1'b0;
            pkt_cnt_q   <= 32'd0;
            data_p1     <= '0;
            user_p1     <= 3'b000;
            last_p1     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            vld_p1      <= vld_p1_d;
            skid_vld_p1 <= skid_vld_p1_d;
            rdy_q       <= ~skid_vld_p1_d;
            if (clear)
                pkt_cnt_q <= 32'd0;
            else if (out_fire && last_p1)
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (load_out) begin
                data_p1 <= out_from_skid ? skid_data_p1 : data_p0;
                user_p1 <= out_from_skid ? skid_user_p1 : bus.i_tuser;
                last_p1 <= out_from_skid ? skid_last_p1 : bus.i_tlast;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data_p1 <= data_p0;
            skid_user_p1 <= bus.i_tuser;
            skid_last_p1 <= bus.i_tlast;
        end
    end

    assign bus.i_tready = rdy_q;
    assign bus.o_tdata  = data_p1;
    assign bus.o_tuser  = user_p1;
    assign bus.o_tlast  = last_p1;
    assign bus.o_tvalid = vld_p1;
    assign pkt_count    = pkt_cnt_q;
endmodule
